baseram_arbiter: RTL and testbench
==================================

BASERAM_ARBITER -- requirements
Module: baseram_arbiter

Interface
REQ-001 SHALL have parameter ACC_CYC, default 2, SRAM access cycles per transfer (legal range 1..7).
REQ-002 SHALL have ports clk_i input 1, the single clock; rst_ni input 1, asynchronous active-low reset.
REQ-003 SHALL have IF requester ports: if_req_i in 1; if_addr_i in 32; if_flush_i in 1 (branch/jump taken, drop fetch); if_gnt_o out 1; if_rvalid_o out 1; if_rdata_o out 32.
REQ-004 SHALL have MEM requester ports: mem_req_i in 1; mem_we_i in 1; mem_be_i in 4; mem_addr_i in 32; mem_wdata_i in 32; mem_gnt_o out 1; mem_rvalid_o out 1; mem_rdata_o out 32.
REQ-005 SHALL have ctl_baseram_hazard_o out 1, the stall request to the IF/ID pipeline register.
REQ-006 SHALL have SRAM ports: base_ram_addr_o out 20; base_ram_be_n_o out 4; base_ram_ce_n_o out 1; base_ram_oe_n_o out 1; base_ram_we_n_o out 1; base_ram_data_o out 32; base_ram_data_oe_o out 1; base_ram_data_i in 32.

Function
REQ-007 SHALL implement FSM states IDLE, READ, WRITE, WHOLD; only IDLE grants.
REQ-008 SHALL assert mem_gnt_o combinationally = IDLE & mem_req_i; if_gnt_o = IDLE & if_req_i & ~mem_req_i (MEM strictly wins).
REQ-009 SHALL latch the granting requester's addr[21:2], be, wdata, we and owner (IF/MEM) on the grant edge; requesters hold req/addr/data stable until gnt.
REQ-010 SHALL treat IF grants as reads with be_n=4'b0000; mem_we_i=1 selects WRITE, else READ.
REQ-011 SHALL, in READ for exactly ACC_CYC cycles, drive ce_n=0, oe_n=0, we_n=1, data_oe=0, addr/be_n from latches.
REQ-012 SHALL capture base_ram_data_i at the end of the last READ cycle, return to IDLE, and pulse the owner's rvalid for exactly that IDLE cycle with the captured data on its rdata.
REQ-013 SHALL hold rdata outputs stable until the next capture for that requester.
REQ-014 SHALL, in WRITE for ACC_CYC cycles, drive ce_n=0, we_n=0, oe_n=1, data_oe=1, data_o=latched wdata; then WHOLD 1 cycle with we_n=1, ce_n=0, data_oe=1 (data hold); then IDLE; no rvalid for writes.
REQ-015 SHALL drive, in IDLE, ce_n=oe_n=we_n=1, be_n=4'hF, data_oe=0.
REQ-016 SHALL allow a new grant in the same IDLE cycle that carries an rvalid pulse (back-to-back read throughput = ACC_CYC+1 cycles).
REQ-017 SHALL assert ctl_baseram_hazard_o = mem_req_i | (state!=IDLE & owner==MEM).
REQ-018 SHALL, when if_flush_i is high during an IF-owned READ or in its rvalid cycle, suppress that if_rvalid_o; SRAM sequencing is unaffected.
REQ-019 SHALL ignore if_flush_i for MEM-owned transfers and when idle.
REQ-020 SHALL continue an in-flight transfer irrespective of requests deasserting; no abort other than reset.

Reset
REQ-021 SHALL on rst_ni=0, immediately and asynchronously: state IDLE; owner IF; all latches 0; if_rdata_o=mem_rdata_o=0; rvalids 0; SRAM controls per REQ-015; base_ram_addr_o=0; base_ram_data_o=0.
REQ-022 SHALL abort any in-flight transfer on reset with no rvalid afterwards; first grant possible in the first cycle after rst_ni rises.

Verification
REQ-023 SHALL cover: ACC_CYC=2, IF read 0x8000_0010, SRAM returns 0x1234_5678 -> gnt cycle T, addr_o=0x00004 with oe_n=0 at T+1..T+2, if_rvalid_o=1 and if_rdata_o=0x1234_5678 at T+3.
REQ-024 SHALL cover: if_req_i and mem_req_i (read 0x8000_0100) same IDLE cycle -> mem_gnt_o=1, if_gnt_o=0, ctl_baseram_hazard_o=1; IF granted in mem_rvalid_o cycle.
REQ-025 SHALL cover: MEM write be=4'b0011, data 0xDEAD_BEEF, ACC_CYC=2 -> we_n=0 two cycles, one WHOLD cycle with we_n=1, data_oe=1, be_n=4'b1100, idle after 4 cycles from gnt, no rvalid.
REQ-026 SHALL cover: if_flush_i pulsed during an IF READ's second cycle -> no if_rvalid_o, if_rdata_o still updated, next grant on schedule.
REQ-027 SHALL cover: rst_ni low mid-WRITE -> we_n, ce_n to 1 and data_oe to 0 without a clock edge; no rvalid after release.
REQ-028 SHALL cover: continuous IF reads, ACC_CYC=1 -> one rvalid every 2 cycles, hazard low throughout.

Source files
------------

// File: rtl/baseram_arbiter.sv
// Arbiter between instruction fetch (IF) and data memory (MEM) for the single-ported
// BaseRAM SRAM. MEM wins arbitration; each transfer runs ACC_CYC SRAM access cycles.
module baseram_arbiter #(
  parameter int ACC_CYC = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_flush_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,

  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_be_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic        mem_gnt_o,
  output logic        mem_rvalid_o,
  output logic [31:0] mem_rdata_o,

  output logic        ctl_baseram_hazard_o,

  output logic [19:0] base_ram_addr_o,
  output logic [3:0]  base_ram_be_n_o,
  output logic        base_ram_ce_n_o,
  output logic        base_ram_oe_n_o,
  output logic        base_ram_we_n_o,
  output logic [31:0] base_ram_data_o,
  output logic        base_ram_data_oe_o,
  input  logic [31:0] base_ram_data_i,

  output logic [1:0]  dbg_state_o
);

  // Handshake: a requester holds req and its payload stable until it sees gnt in the
  // same cycle; the grant edge latches the payload. rvalid is a one-cycle pulse with
  // rdata valid alongside, and rdata stays put until that requester's next read.

  typedef enum logic [1:0] {IDLE, READ, WRITE, WHOLD} state_t;

  localparam logic [2:0] LAST = 3'(ACC_CYC - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        owner_q;          // 1 = MEM owns the transfer, 0 = IF
  logic [19:0] addr_q;
  logic [3:0]  be_n_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic        flushed_q;
  logic        if_rv_q, mem_rv_q;
  logic [31:0] if_rdata_q, mem_rdata_q;
  logic        last_cyc;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{if_addr_i[31:22], if_addr_i[1:0],
                              mem_addr_i[31:22], mem_addr_i[1:0]};

  assign mem_gnt_o = (state_q == IDLE) & mem_req_i;
  assign if_gnt_o  = (state_q == IDLE) & if_req_i & ~mem_req_i;
  assign last_cyc  = (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mem_gnt_o) begin
          state_d = mem_we_i ? WRITE : READ;
          cnt_d   = 3'd0;
        end else if (if_gnt_o) begin
          state_d = READ;
          cnt_d   = 3'd0;
        end
      end
      READ: begin
        if (last_cyc) state_d = IDLE;
        else          cnt_d   = cnt_q + 3'd1;
      end
      WRITE: begin
        if (last_cyc) state_d = WHOLD;
        else          cnt_d   = cnt_q + 3'd1;
      end
      WHOLD:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q     <= 1'b0;
      addr_q      <= 20'd0;
      be_n_q      <= 4'd0;
      wdata_q     <= 32'd0;
      we_q        <= 1'b0;
      flushed_q   <= 1'b0;
      if_rv_q     <= 1'b0;
      mem_rv_q    <= 1'b0;
      if_rdata_q  <= 32'd0;
      mem_rdata_q <= 32'd0;
    end else begin
      if_rv_q  <= 1'b0;
      mem_rv_q <= 1'b0;
      if (mem_gnt_o) begin
        owner_q   <= 1'b1;
        addr_q    <= mem_addr_i[21:2];
        be_n_q    <= ~mem_be_i;
        wdata_q   <= mem_wdata_i;
        we_q      <= mem_we_i;
        flushed_q <= 1'b0;
      end else if (if_gnt_o) begin
        owner_q   <= 1'b0;
        addr_q    <= if_addr_i[21:2];
        be_n_q    <= 4'b0000;
        wdata_q   <= 32'd0;
        we_q      <= 1'b0;
        flushed_q <= 1'b0;
      end
      if (state_q == READ && !owner_q && if_flush_i) flushed_q <= 1'b1;
      // A flush seen anywhere in the IF read kills the pulse, but the data still lands.
      if (state_q == READ && last_cyc) begin
        if (owner_q) begin
          mem_rdata_q <= base_ram_data_i;
          mem_rv_q    <= 1'b1;
        end else begin
          if_rdata_q  <= base_ram_data_i;
          if_rv_q     <= ~(flushed_q | if_flush_i);
        end
      end
    end
  end

  assign if_rvalid_o  = if_rv_q & ~if_flush_i;
  assign if_rdata_o   = if_rdata_q;
  assign mem_rvalid_o = mem_rv_q;
  assign mem_rdata_o  = mem_rdata_q;

  assign ctl_baseram_hazard_o = mem_req_i | ((state_q != IDLE) & owner_q);

  assign base_ram_addr_o    = addr_q;
  assign base_ram_be_n_o    = (state_q == IDLE) ? 4'hF : be_n_q;
  assign base_ram_ce_n_o    = (state_q == IDLE);
  assign base_ram_oe_n_o    = (state_q != READ);
  assign base_ram_we_n_o    = ~((state_q == WRITE) & we_q);
  assign base_ram_data_o    = wdata_q;
  assign base_ram_data_oe_o = ((state_q == WRITE) | (state_q == WHOLD)) & we_q;

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_baseram_arbiter.sv
// Directed bench for baseram_arbiter: ACC_CYC=2 instance for arbitration, write, flush
// and reset cases; ACC_CYC=1 instance for back-to-back IF read throughput.
module tb_baseram_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ACC_CYC = 2 instance
  logic        if_req, if_flush, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        hazard;
  logic [19:0] ram_addr;
  logic [3:0]  ram_be_n;
  logic        ram_ce_n, ram_oe_n, ram_we_n, ram_data_oe;
  logic [31:0] ram_data_o, ram_rd;
  logic [1:0]  dbg_state;

  // ACC_CYC = 1 instance
  logic        b_if_req, b_if_gnt, b_if_rvalid, b_mem_gnt, b_mem_rvalid, b_hazard;
  logic [31:0] b_if_addr, b_if_rdata, b_mem_rdata;
  logic [19:0] b_ram_addr;
  logic [3:0]  b_ram_be_n;
  logic        b_ram_ce_n, b_ram_oe_n, b_ram_we_n, b_ram_data_oe;
  logic [31:0] b_ram_data_o, b_ram_rd;
  logic [1:0]  b_dbg_state;

  logic [31:0] if_exp_q[$];
  logic [31:0] mem_exp_q[$];
  logic [31:0] b_exp_q[$];

  // SRAM model for the throughput instance: contents derived from the word address.
  assign b_ram_rd = {12'hA5A, b_ram_addr};

  baseram_arbiter #(.ACC_CYC(2)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
    .if_gnt_o(if_gnt), .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_be_i(mem_be), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .mem_gnt_o(mem_gnt), .mem_rvalid_o(mem_rvalid),
    .mem_rdata_o(mem_rdata), .ctl_baseram_hazard_o(hazard),
    .base_ram_addr_o(ram_addr), .base_ram_be_n_o(ram_be_n), .base_ram_ce_n_o(ram_ce_n),
    .base_ram_oe_n_o(ram_oe_n), .base_ram_we_n_o(ram_we_n), .base_ram_data_o(ram_data_o),
    .base_ram_data_oe_o(ram_data_oe), .base_ram_data_i(ram_rd), .dbg_state_o(dbg_state)
  );

  baseram_arbiter #(.ACC_CYC(1)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .if_req_i(b_if_req), .if_addr_i(b_if_addr), .if_flush_i(1'b0),
    .if_gnt_o(b_if_gnt), .if_rvalid_o(b_if_rvalid), .if_rdata_o(b_if_rdata),
    .mem_req_i(1'b0), .mem_we_i(1'b0), .mem_be_i(4'h0), .mem_addr_i(32'h0),
    .mem_wdata_i(32'h0), .mem_gnt_o(b_mem_gnt), .mem_rvalid_o(b_mem_rvalid),
    .mem_rdata_o(b_mem_rdata), .ctl_baseram_hazard_o(b_hazard),
    .base_ram_addr_o(b_ram_addr), .base_ram_be_n_o(b_ram_be_n), .base_ram_ce_n_o(b_ram_ce_n),
    .base_ram_oe_n_o(b_ram_oe_n), .base_ram_we_n_o(b_ram_we_n), .base_ram_data_o(b_ram_data_o),
    .base_ram_data_oe_o(b_ram_data_oe), .base_ram_data_i(b_ram_rd), .dbg_state_o(b_dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every rvalid pulse pops the oldest expected read for that requester.
  always @(negedge clk) begin
    if (rst_n) begin
      if (if_rvalid) begin
        if (if_exp_q.size() == 0) chk("if_rvalid_unexpected", 32'd1, 32'd0);
        else chk("if_rdata_sb", if_rdata, if_exp_q.pop_front());
      end
      if (mem_rvalid) begin
        if (mem_exp_q.size() == 0) chk("mem_rvalid_unexpected", 32'd1, 32'd0);
        else chk("mem_rdata_sb", mem_rdata, mem_exp_q.pop_front());
      end
      if (b_if_rvalid) begin
        if (b_exp_q.size() == 0) chk("b_rvalid_unexpected", 32'd1, 32'd0);
        else chk("b_rdata_sb", b_if_rdata, b_exp_q.pop_front());
      end
    end
  end

  initial begin
    if_req = 0; if_addr = 0; if_flush = 0;
    mem_req = 0; mem_we = 0; mem_be = 0; mem_addr = 0; mem_wdata = 0;
    ram_rd = 0; b_if_req = 0; b_if_addr = 0;

    // Reset state
    @(negedge clk);
    chk("rst_ce_n", ram_ce_n, 1);
    chk("rst_oe_n", ram_oe_n, 1);
    chk("rst_we_n", ram_we_n, 1);
    chk("rst_be_n", ram_be_n, 4'hF);
    chk("rst_data_oe", ram_data_oe, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_data_o", ram_data_o, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_rvalids", {if_rvalid, mem_rvalid}, 0);
    tick();
    rst_n = 1;

    // IF read, 2 access cycles
    if_req = 1; if_addr = 32'h8000_0010; ram_rd = 32'h1234_5678;
    @(negedge clk);
    chk("t1_if_gnt", if_gnt, 1);
    chk("t1_hazard", hazard, 0);
    if_exp_q.push_back(32'h1234_5678);
    tick(); if_req = 0;
    @(negedge clk);
    chk("t1_oe_n_c1", ram_oe_n, 0);
    chk("t1_ce_n_c1", ram_ce_n, 0);
    chk("t1_we_n_c1", ram_we_n, 1);
    chk("t1_addr", ram_addr, 20'h00004);
    chk("t1_be_n", ram_be_n, 4'b0000);
    tick();
    @(negedge clk);
    chk("t1_oe_n_c2", ram_oe_n, 0);
    tick();
    @(negedge clk);
    chk("t1_if_rvalid", if_rvalid, 1);
    chk("t1_idle_oe_n", ram_oe_n, 1);

    // Simultaneous requests: MEM wins, IF granted in the mem_rvalid cycle
    tick();
    if_req = 1; if_addr = 32'h8000_0020;
    mem_req = 1; mem_we = 0; mem_be = 4'hF; mem_addr = 32'h8000_0100; ram_rd = 32'hCAFE_0001;
    @(negedge clk);
    chk("t2_mem_gnt", mem_gnt, 1);
    chk("t2_if_gnt", if_gnt, 0);
    chk("t2_hazard", hazard, 1);
    mem_exp_q.push_back(32'hCAFE_0001);
    tick(); mem_req = 0;
    @(negedge clk);
    chk("t2_hazard_busy", hazard, 1);
    chk("t2_addr", ram_addr, 20'h00040);
    chk("t2_if_gnt_busy", if_gnt, 0);
    tick();
    @(negedge clk);
    tick();
    ram_rd = 32'h0BAD_F00D;
    @(negedge clk);
    chk("t2_mem_rvalid", mem_rvalid, 1);
    chk("t2_if_gnt_rv", if_gnt, 1);
    chk("t2_hazard_idle", hazard, 0);
    if_exp_q.push_back(32'h0BAD_F00D);
    tick(); if_req = 0;
    tick();
    tick();
    @(negedge clk);
    chk("t2_if_rvalid", if_rvalid, 1);
    chk("t2_mem_rdata_hold", mem_rdata, 32'hCAFE_0001);

    // MEM write with partial byte enables
    tick();
    mem_req = 1; mem_we = 1; mem_be = 4'b0011; mem_addr = 32'h8000_0200;
    mem_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t3_mem_gnt", mem_gnt, 1);
    tick(); mem_req = 0; mem_we = 0;
    @(negedge clk);
    chk("t3_we_n_c1", ram_we_n, 0);
    chk("t3_oe_n", ram_oe_n, 1);
    chk("t3_data_oe", ram_data_oe, 1);
    chk("t3_data_o", ram_data_o, 32'hDEAD_BEEF);
    chk("t3_be_n", ram_be_n, 4'b1100);
    chk("t3_hazard", hazard, 1);
    tick();
    @(negedge clk);
    chk("t3_we_n_c2", ram_we_n, 0);
    tick();
    @(negedge clk);
    chk("t3_whold_we_n", ram_we_n, 1);
    chk("t3_whold_ce_n", ram_ce_n, 0);
    chk("t3_whold_data_oe", ram_data_oe, 1);
    chk("t3_whold_be_n", ram_be_n, 4'b1100);
    tick();
    @(negedge clk);
    chk("t3_idle_ce_n", ram_ce_n, 1);
    chk("t3_idle_data_oe", ram_data_oe, 0);
    chk("t3_no_rvalid", mem_rvalid, 0);

    // Flush in the second READ cycle: no rvalid, rdata updated, next grant on time
    tick();
    if_req = 1; if_addr = 32'h8000_0040; ram_rd = 32'h55AA_55AA;
    @(negedge clk);
    chk("t4_if_gnt", if_gnt, 1);
    tick(); if_req = 0;
    tick(); if_flush = 1;
    @(negedge clk);
    tick(); if_flush = 0;
    if_req = 1; if_addr = 32'h8000_0044; ram_rd = 32'h1111_2222;
    @(negedge clk);
    chk("t4_no_rvalid", if_rvalid, 0);
    chk("t4_rdata_upd", if_rdata, 32'h55AA_55AA);
    chk("t4_next_gnt", if_gnt, 1);
    if_exp_q.push_back(32'h1111_2222);
    tick(); if_req = 0;
    tick();
    tick();
    @(negedge clk);
    chk("t4_rvalid2", if_rvalid, 1);

    // Asynchronous reset in the middle of a write
    tick();
    mem_req = 1; mem_we = 1; mem_be = 4'hF; mem_addr = 32'h8000_0300;
    mem_wdata = 32'h0F0F_0F0F;
    @(negedge clk);
    chk("t5_mem_gnt", mem_gnt, 1);
    tick(); mem_req = 0; mem_we = 0;
    @(negedge clk);
    chk("t5_we_n_pre", ram_we_n, 0);
    #2 rst_n = 0;
    #1;
    chk("t5_we_n_rst", ram_we_n, 1);
    chk("t5_ce_n_rst", ram_ce_n, 1);
    chk("t5_data_oe_rst", ram_data_oe, 0);
    chk("t5_if_rdata_rst", if_rdata, 0);
    chk("t5_data_o_rst", ram_data_o, 0);
    tick();
    rst_n = 1;
    if_req = 1; if_addr = 32'h8000_0080; ram_rd = 32'h7654_3210;
    @(negedge clk);
    chk("t5_first_gnt", if_gnt, 1);
    chk("t5_no_mem_rvalid", mem_rvalid, 0);
    if_exp_q.push_back(32'h7654_3210);
    tick(); if_req = 0;
    @(negedge clk);
    chk("t5_read_oe_n", ram_oe_n, 0);
    tick();
    tick();
    @(negedge clk);
    chk("t5_if_rvalid", if_rvalid, 1);
    chk("t5_mem_rvalid_after", mem_rvalid, 0);

    // Continuous IF reads on the ACC_CYC=1 instance
    tick();
    b_if_req = 1; b_if_addr = 32'h8000_0000;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("t6_hazard", b_hazard, 0);
      chk("t6_gnt", {31'd0, b_if_gnt}, {31'd0, (i % 2 == 0)});
      chk("t6_rvalid", {31'd0, b_if_rvalid}, {31'd0, (i % 2 == 0) && (i >= 2)});
      if (b_if_gnt) b_exp_q.push_back({12'hA5A, b_if_addr[21:2]});
      tick();
      if (i % 2 == 0) b_if_addr = b_if_addr + 32'd4;
    end
    b_if_req = 0;
    @(negedge clk);
    chk("t6_last_rvalid", b_if_rvalid, 1);
    tick();
    tick();

    chk("if_q_empty", if_exp_q.size(), 0);
    chk("mem_q_empty", mem_exp_q.size(), 0);
    chk("b_q_empty", b_exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
